alu_mul_seq: RTL and testbench

- Multi-cycle 8x8 -> 16 unsigned multiply sequencer. It is the initiator side of the ALU interface.
- Drives the ALU's oper / a_in_hi / a_in_lo / b_in / proc_flags_in inputs and consumes its out_hi / out_lo / proc_flags_out.
- Implements shift-and-add using only alu_op_add and alu_op_rorcp.
- Sits beside the ALU in the CPU datapath; the control unit uses it for a MUL instruction.

---
 rtl/pkg_alu.sv | 11 +
 rtl/pkg_alu_mul.sv | 5 +
 rtl/pkg_pflags.sv | 4 +
 rtl/alu_mul_seq.sv | 131 +++++++++++++
 tb/tb_alu_mul_seq.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/pkg_alu.sv
// ALU operation encoding shared across the datapath.
package pkg_alu;
  typedef enum logic [2:0] {
    alu_op_add,
    alu_op_sub,
    alu_op_and,
    alu_op_or,
    alu_op_xor,
    alu_op_rorcp
  } alu_oper;
endpackage

// File: rtl/pkg_alu_mul.sv
// Types and constants for the sequential shift-and-add multiplier.
package pkg_alu_mul;
  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} mul_state_t;
  localparam int MUL_ITER_COUNT = 8;
endpackage

// File: rtl/pkg_pflags.sv
// Processor flag slot positions shared by the ALU and its initiators.
package pkg_pflags;
  localparam int pf_slot_c = 0;
endpackage

// File: rtl/alu_mul_seq.sv
// 8x8 -> 16 unsigned multiply sequencer driving an external combinational ALU
// with add and rotate-right-through-carry steps only.
//
// state | meaning
// IDLE  | waiting for start; ALU idles on add with zero operands
// ADD   | acc_hi += (acc_lo[0] ? mcand : 0), carry captured
// SHIFT | {carry, acc_hi, acc_lo} rotated right by one through the ALU
// DONE  | product published, done pulsed for one cycle
`ifndef ALU_INOUT_WIDTH
`define ALU_INOUT_WIDTH 8
`endif
`ifndef PROC_FLAGS_MSB_POS
`define PROC_FLAGS_MSB_POS 3
`endif

module alu_mul_seq
  import pkg_alu_mul::*;
#(
  parameter int INOUT_WIDTH = `ALU_INOUT_WIDTH,
  parameter int ITER_COUNT  = MUL_ITER_COUNT
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [INOUT_WIDTH-1:0]       mul_a,
  input  logic [INOUT_WIDTH-1:0]       mul_b,
  output logic                         busy,
  output logic                         done,
  output logic [INOUT_WIDTH-1:0]       prod_hi,
  output logic [INOUT_WIDTH-1:0]       prod_lo,
  output logic                         prod_z,
  output pkg_alu::alu_oper             alu_oper,
  output logic [INOUT_WIDTH-1:0]       alu_a_hi,
  output logic [INOUT_WIDTH-1:0]       alu_a_lo,
  output logic [INOUT_WIDTH-1:0]       alu_b,
  output logic [`PROC_FLAGS_MSB_POS:0] alu_flags_in,
  input  logic [INOUT_WIDTH-1:0]       alu_out_hi,
  input  logic [INOUT_WIDTH-1:0]       alu_out_lo,
  input  logic [`PROC_FLAGS_MSB_POS:0] alu_flags_out
);

  localparam int ITER_W = (ITER_COUNT > 1) ? $clog2(ITER_COUNT) : 1;
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(ITER_COUNT - 1);

  mul_state_t             state, state_nxt;
  logic [INOUT_WIDTH-1:0] mcand, acc_hi, acc_lo;
  logic                   carry_r;
  logic [ITER_W-1:0]      iter;
  logic                   alu_c;
  logic                   unused_flags;

  assign alu_c        = alu_flags_out[pkg_pflags::pf_slot_c];
  assign unused_flags = ^alu_flags_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    busy         = (state != IDLE);
    done         = 1'b0;
    alu_oper     = pkg_alu::alu_op_add;
    alu_a_hi     = '0;
    alu_a_lo     = '0;
    alu_b        = '0;
    alu_flags_in = '0;
    case (state)
      IDLE: if (start) state_nxt = ADD;
      ADD: begin
        alu_a_lo  = acc_hi;
        alu_b     = acc_lo[0] ? mcand : '0;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        alu_oper                           = pkg_alu::alu_op_rorcp;
        alu_a_hi                           = acc_hi;
        alu_a_lo                           = acc_lo;
        alu_flags_in[pkg_pflags::pf_slot_c] = carry_r;
        state_nxt                          = (iter == ITER_LAST) ? DONE : ADD;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The add carry is the 17th product bit; rorcp shifts it into acc_hi[MSB].
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      carry_r <= 1'b0;
      iter    <= '0;
      prod_hi <= '0;
      prod_lo <= '0;
      prod_z  <= 1'b1;
    end else begin
      case (state)
        IDLE: if (start) begin
          mcand   <= mul_a;
          acc_hi  <= '0;
          acc_lo  <= mul_b;
          carry_r <= 1'b0;
          iter    <= '0;
        end
        ADD: begin
          acc_hi  <= alu_out_lo;
          carry_r <= alu_c;
        end
        SHIFT: begin
          acc_hi  <= alu_out_hi;
          acc_lo  <= alu_out_lo;
          carry_r <= alu_c;
          if (iter != ITER_LAST) iter <= iter + 1'b1;
        end
        DONE: begin
          prod_hi <= acc_hi;
          prod_lo <= acc_lo;
          prod_z  <= ({acc_hi, acc_lo} == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: behavioural ALU alongside the DUT, products checked
// through a scoreboard against plain integer multiplication.
`ifndef PROC_FLAGS_MSB_POS
`define PROC_FLAGS_MSB_POS 3
`endif

module tb_alu_mul_seq;
  localparam int C = pkg_pflags::pf_slot_c;

  logic                         clk;
  logic                         reset_n;
  logic                         start;
  logic [7:0]                   mul_a, mul_b;
  logic                         busy, done;
  logic [7:0]                   prod_hi, prod_lo;
  logic                         prod_z;
  pkg_alu::alu_oper             alu_oper;
  logic [7:0]                   alu_a_hi, alu_a_lo, alu_b;
  logic [`PROC_FLAGS_MSB_POS:0] alu_flags_in;
  logic [7:0]                   alu_out_hi, alu_out_lo;
  logic [`PROC_FLAGS_MSB_POS:0] alu_flags_out;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];
  logic [16:0] pend;
  bit          pend_v = 0;

  alu_mul_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mul_a(mul_a), .mul_b(mul_b),
    .busy(busy), .done(done), .prod_hi(prod_hi), .prod_lo(prod_lo), .prod_z(prod_z),
    .alu_oper(alu_oper), .alu_a_hi(alu_a_hi), .alu_a_lo(alu_a_lo), .alu_b(alu_b),
    .alu_flags_in(alu_flags_in), .alu_out_hi(alu_out_hi), .alu_out_lo(alu_out_lo),
    .alu_flags_out(alu_flags_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALU: add sets carry out; rorcp rotates {c, hi, lo} right by one.
  always_comb begin
    alu_out_hi    = '0;
    alu_out_lo    = '0;
    alu_flags_out = '0;
    case (alu_oper)
      pkg_alu::alu_op_add:
        {alu_flags_out[C], alu_out_lo} = {1'b0, alu_a_lo} + {1'b0, alu_b};
      pkg_alu::alu_op_rorcp: begin
        {alu_out_hi, alu_out_lo} = {alu_flags_in[C], alu_a_hi, alu_a_lo[7:1]};
        alu_flags_out[C]         = alu_a_lo[0];
      end
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a done cycle claims the oldest expectation; prod_* is compared
  // one cycle later, once DONE has published it.
  always @(negedge clk) begin
    if (pend_v) begin
      chk("prod_hi", 32'(prod_hi), 32'(pend[15:8]));
      chk("prod_lo", 32'(prod_lo), 32'(pend[7:0]));
      chk("prod_z", 32'(prod_z), 32'(pend[16]));
      pend_v = 0;
    end
    if (reset_n && done) begin
      if (exp_q.size() == 0) chk("done_unexpected", 32'(done), 32'd0);
      else begin
        pend   = exp_q.pop_front();
        pend_v = 1;
      end
    end
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    @(negedge clk);
    mul_a = a;
    mul_b = b;
    start = 1'b1;
    @(posedge clk);
    p = {8'd0, a} * {8'd0, b};
    exp_q.push_back({p == 16'd0, p});
    #1;
    start = 1'b0;
    mul_a = 8'($urandom);
    mul_b = 8'($urandom);
  endtask

  task automatic do_mul(input logic [7:0] a, input logic [7:0] b, input bit stray_busy,
                        input bit stray_done, input bit hold_chk, input logic [15:0] prev);
    issue(a, b);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      chk("busy_during_op", 32'(busy), 32'd1);
      if (k <= 16) begin
        chk("done_early", 32'(done), 32'd0);
        chk("oper_seq", 32'(alu_oper),
            (k % 2 == 1) ? 32'(pkg_alu::alu_op_add) : 32'(pkg_alu::alu_op_rorcp));
        if (a == 8'd0 && (k % 2 == 1)) chk("alu_b_zero_mcand", 32'(alu_b), 32'd0);
      end else begin
        chk("done_at_17", 32'(done), 32'd1);
      end
      if (hold_chk) chk("prod_hold", 32'({prod_hi, prod_lo}), 32'(prev));
      if (stray_busy && k == 5) begin
        start = 1'b1;
        mul_a = 8'($urandom);
        mul_b = 8'($urandom);
      end
      if (stray_busy && k == 6) start = 1'b0;
      if (stray_done && k == 17) start = 1'b1;
    end
    if (stray_done) begin
      @(negedge clk);
      chk("start_in_done_ignored", 32'(busy), 32'd0);
      start = 1'b0;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    mul_a   = '0;
    mul_b   = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_prod", 32'({prod_hi, prod_lo}), 32'd0);
    chk("rst_prod_z", 32'(prod_z), 32'd1);
    chk("rst_oper", 32'(alu_oper), 32'(pkg_alu::alu_op_add));
    reset_n = 1'b1;

    do_mul(8'h0C, 8'h0A, 0, 0, 0, 16'h0);
    do_mul(8'hFF, 8'hFF, 0, 0, 0, 16'h0);
    do_mul(8'h00, 8'h55, 0, 0, 0, 16'h0);
    do_mul(8'h80, 8'h02, 1, 0, 0, 16'h0);
    do_mul(8'h37, 8'h91, 0, 0, 0, 16'h0);
    do_mul(8'h12, 8'h34, 0, 0, 1, 16'h37 * 16'h91);
    do_mul(8'h21, 8'h07, 0, 1, 0, 16'h0);

    // Abort mid-operation; the previous product is nonzero so clearing is visible.
    issue(8'h5A, 8'h33);
    repeat (8) @(negedge clk);
    reset_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_prod", 32'({prod_hi, prod_lo}), 32'd0);
    chk("abort_prod_z", 32'(prod_z), 32'd1);
    repeat (2) @(negedge clk);
    chk("abort_no_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    do_mul(8'h03, 8'h05, 0, 0, 0, 16'h0);

    for (int i = 0; i < 20; i++)
      do_mul(8'($urandom), 8'($urandom), bit'($urandom_range(0, 1)),
             bit'($urandom_range(0, 1)), 0, 16'h0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
